// File: rtl/debounce_fsm.sv
// Debounce filter: synchronises a raw bouncy level, then qualifies every level
// change over DB_CYCLES stable cycles before reporting it on db_level.
module debounce_fsm #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 1000000,
   parameter int CNT_W       = $clog2(DB_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_raw,
   output logic db_level,
   output logic db_busy
);

   typedef enum logic [1:0] {
      ST_ZERO  = 2'b00,
      ST_WAIT1 = 2'b01,
      ST_ONE   = 2'b10,
      ST_WAIT0 = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sw_sync;
   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   db_level_q;
   logic                   db_level_d;
   logic                   db_busy_q;
   logic                   db_busy_d;

   assign sw_sync  = sync_q[SYNC_STAGES-1];
   assign db_level = db_level_q;
   assign db_busy  = db_busy_q;

   // Synchroniser shift: sw_raw enters at bit 0, sw_sync leaves at the top.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
   end

   // Next state, counter and output decode; outputs follow the next state so
   // the registered copies always match the state register.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      db_level_d = 1'b0;
      db_busy_d  = 1'b0;
      case (state_q)
         ST_ZERO: begin
            if (sw_sync) begin
               state_d = ST_WAIT1;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = ST_ZERO;
            end
         end
         ST_WAIT1: begin
            if (!sw_sync) begin
               state_d = ST_ZERO;
            end else if (cnt_q == CNT_ZERO) begin
               state_d = ST_ONE;
            end else begin
               cnt_d = cnt_q - CNT_DEC;
            end
         end
         ST_ONE: begin
            if (!sw_sync) begin
               state_d = ST_WAIT0;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_WAIT0: begin
            if (sw_sync) begin
               state_d = ST_ONE;
            end else if (cnt_q == CNT_ZERO) begin
               state_d = ST_ZERO;
            end else begin
               cnt_d = cnt_q - CNT_DEC;
            end
         end
         default: begin
            state_d = ST_ZERO;
            cnt_d   = CNT_ZERO;
         end
      endcase
      case (state_d)
         ST_WAIT1: begin
            db_level_d = 1'b0;
            db_busy_d  = 1'b1;
         end
         ST_ONE: begin
            db_level_d = 1'b1;
            db_busy_d  = 1'b0;
         end
         ST_WAIT0: begin
            db_level_d = 1'b1;
            db_busy_d  = 1'b1;
         end
         default: begin
            db_level_d = 1'b0;
            db_busy_d  = 1'b0;
         end
      endcase
   end

   // State, counter, synchroniser and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         state_q    <= ST_ZERO;
         cnt_q      <= CNT_ZERO;
         db_level_q <= 1'b0;
         db_busy_q  <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         db_level_q <= db_level_d;
         db_busy_q  <= db_busy_d;
      end
   end

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm: a per-cycle vector table for the main
// sequences plus hand-written reset and DB_CYCLES=1 sequences.
module tb_debounce_fsm;

   logic clk;
   logic reset_n;
   logic sw_raw;
   logic db_level;
   logic db_busy;
   logic sw_raw1;
   logic db_level1;
   logic db_busy1;

   int errors;
   int checks;

   typedef struct packed {
      logic sw;
      logic lvl;
      logic bsy;
   } vec_t;

   vec_t tbl[$];

   debounce_fsm #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .sw_raw   (sw_raw),
      .db_level (db_level),
      .db_busy  (db_busy)
   );

   debounce_fsm #(.SYNC_STAGES(2), .DB_CYCLES(1)) dut1 (
      .clk      (clk),
      .reset_n  (reset_n),
      .sw_raw   (sw_raw1),
      .db_level (db_level1),
      .db_busy  (db_busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input logic sw, input logic lvl, input logic bsy);
      vec_t v;
      v.sw  = sw;
      v.lvl = lvl;
      v.bsy = bsy;
      tbl.push_back(v);
   endtask

   // Drive sw_raw on the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic sw);
      @(negedge clk);
      sw_raw = sw;
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic sw);
      @(negedge clk);
      sw_raw1 = sw;
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      reset_n = 1'b0;
      sw_raw  = 1'b0;
      sw_raw1 = 1'b0;

      // idle
      add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
      // clean press
      add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b1); add(1'b1, 1'b0, 1'b1); add(1'b1, 1'b0, 1'b1);
      add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b0);
      // glitch reject: three low cycles while stable high
      add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b1, 1'b1);
      add(1'b1, 1'b1, 1'b1); add(1'b1, 1'b1, 1'b1); add(1'b1, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b0);
      // clean release
      add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 1'b1); add(1'b0, 1'b1, 1'b1); add(1'b0, 1'b1, 1'b1);
      add(1'b0, 0, 1'b0);    add(1'b0, 1'b0, 1'b0);
      // bounce on press: 1,0,1,0,1 then held
      add(1'b1, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0); add(1'b1, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0); add(1'b1, 1'b0, 1'b1); add(1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1); add(1'b1, 1'b0, 1'b1); add(1'b1, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b1); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b0);

      // reset state, before any clock edge
      #3;
      chk("reset_level", db_level, 1'b0);
      chk("reset_busy", db_busy, 1'b0);
      chk("reset_level1", db_level1, 1'b0);
      chk("reset_busy1", db_busy1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].sw);
         chk($sformatf("vec%0d_level", i), db_level, tbl[i].lvl);
         chk($sformatf("vec%0d_busy", i), db_busy, tbl[i].bsy);
      end

      // asynchronous reset from the stable-high state
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset_from_one_level", db_level, 1'b0);
      chk("areset_from_one_busy", db_busy, 1'b0);
      @(negedge clk);
      sw_raw  = 1'b0;
      reset_n = 1'b1;
      step(1'b0);
      step(1'b0);

      // reach wait1 with cnt=2, then reset mid-cycle
      step(1'b1);
      step(1'b1);
      step(1'b1);
      chk("mid_e3_busy", db_busy, 1'b1);
      step(1'b1);
      chk("mid_e4_busy", db_busy, 1'b1);
      chk("mid_e4_level", db_level, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_reset_level", db_level, 1'b0);
      chk("mid_reset_busy", db_busy, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst_e%0d_level", e), db_level, (e >= 7) ? 1'b1 : 1'b0);
         chk($sformatf("post_rst_e%0d_busy", e), db_busy,
             (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
      end

      // DB_CYCLES=1: single-cycle pulse never sets db_level
      for (int e = 1; e <= 6; e++) begin
         step1((e == 1) ? 1'b1 : 1'b0);
         chk($sformatf("db1_pulse_e%0d_level", e), db_level1, 1'b0);
         chk($sformatf("db1_pulse_e%0d_busy", e), db_busy1, (e == 3) ? 1'b1 : 1'b0);
      end
      // DB_CYCLES=1: held high rises after edge 4
      for (int e = 1; e <= 6; e++) begin
         step1(1'b1);
         chk($sformatf("db1_hold_e%0d_level", e), db_level1, (e >= 4) ? 1'b1 : 1'b0);
         chk($sformatf("db1_hold_e%0d_busy", e), db_busy1, (e == 3) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
